micro: RTL and testbench

MICRO -- requirements
Module: micro

---
 rtl/micro.sv | 167 ++++++++++++++++
 tb/tb_micro.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro.sv
// micro: single-cycle 8-bit load/store micro-controller.
//   clk_i  - single clock; every state update happens on its rising edge
//   rst_ni - asynchronous active-low reset (PC, register file, flags, data memory)
// There are no other ports. Program memory (u_pmem.mem) is preloaded through hierarchy.
// Instruction word, MSB first:
//   RegWrite MemWrite Jump FlagWrite ALUSrc MemToReg COND[2:0] ALUOP[2:0] LIT[7:0] rsB rsA rd

// Program ROM. It is combinational and has no reset; its contents come from outside.
//   i_addr - fetch address (PC)
//   o_data - instruction word
module micro_pmem #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       o_data
);
  logic [31:0] mem [2**ADDR_W];
  assign o_data = mem[i_addr];
endmodule

// Data RAM: combinational read, write on the clock edge, every word cleared by reset.
//   i_we/i_addr/i_wdata - write port (the address is shared with the read port)
//   o_rdata             - read data at i_addr
module micro_dmem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];
endmodule

module micro #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input logic clk_i,
  input logic rst_ni
);
  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       jmp;
    logic       fw;
    logic       src;
    logic       m2r;
    logic [2:0] cond;
    logic [2:0] op;
    logic [7:0] lit;
    logic [3:0] rb;
    logic [3:0] ra;
    logic [3:0] rd;
  } ins_t;

  localparam int MSB = DATA_W - 1;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rf [16];
  logic              r_z, r_n, r_c, r_v;

  logic [31:0]       w_pdata;
  ins_t              w_ins;
  logic [DATA_W-1:0] w_a, w_b, w_res, w_mrd;
  logic [DATA_W:0]   w_sum;
  logic [ADDR_W-1:0] w_lit_addr;
  logic              w_c, w_v, w_take;

  micro_pmem #(.ADDR_W(ADDR_W)) u_pmem (
    .i_addr (r_pc),
    .o_data (w_pdata)
  );

  assign w_ins      = ins_t'(w_pdata);
  assign w_lit_addr = ADDR_W'(w_ins.lit);

  // The data memory is always addressed by the literal, never by the ALU.
  micro_dmem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dmem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_we    (w_ins.mw),
    .i_addr  (w_lit_addr),
    .i_wdata (w_a),
    .o_rdata (w_mrd)
  );

  assign w_a = r_rf[w_ins.ra];
  assign w_b = w_ins.src ? DATA_W'(w_ins.lit) : r_rf[w_ins.rb];

  // One extra bit on add/sub: it holds the carry-out for ADD and the borrow
  // (A < B unsigned) for SUB.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_ins.op)
      3'd0: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      3'd1: begin
        w_sum = {1'b0, w_a} - {1'b0, w_b};
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      3'd2: w_res = w_a & w_b;
      3'd3: w_res = w_a | w_b;
      3'd4: w_res = w_a ^ w_b;
      3'd5: w_res = ~w_a;
      3'd6: begin w_res = w_a << 1; w_c = w_a[MSB]; end
      default: begin w_res = w_a >> 1; w_c = w_a[0]; end
    endcase
  end

  // The condition is evaluated on the flags already in the registers, i.e. on
  // flags written by an earlier instruction.
  always_comb begin
    case (w_ins.cond)
      3'd0:    w_take = 1'b1;
      3'd1:    w_take = r_z;
      3'd2:    w_take = !r_z;
      3'd3:    w_take = r_c;
      3'd4:    w_take = !r_c;
      3'd5:    w_take = r_n;
      3'd6:    w_take = !r_n;
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc <= '0;
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
      r_z  <= 1'b0;
      r_n  <= 1'b0;
      r_c  <= 1'b0;
      r_v  <= 1'b0;
    end else begin
      r_pc <= (w_ins.jmp && w_take) ? w_lit_addr : r_pc + ADDR_W'(1);
      if (w_ins.rw) r_rf[w_ins.rd] <= w_ins.m2r ? w_mrd : w_res;
      if (w_ins.fw) begin
        r_z <= (w_res == '0);
        r_n <= w_res[MSB];
        r_c <= w_c;
        r_v <= w_v;
      end
    end
  end
endmodule

// File: tb/tb_micro.sv
module tb_micro;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  micro #(.DATA_W(8), .ADDR_W(8)) u_micro (
    .clk_i  (clk_i),
    .rst_ni (rst_ni)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] zncv;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] zncv;
  } exp_t;

  vec_t vt [12];
  exp_t exp_q [$];
  exp_t e;

  function automatic logic [31:0] enc(input logic rw, mw, j, fw, src, m2r,
                                      input logic [2:0] cond, op,
                                      input logic [7:0] lit,
                                      input logic [3:0] rb, ra, rd);
    return {rw, mw, j, fw, src, m2r, cond, op, lit, rb, ra, rd};
  endfunction

  function automatic logic [31:0] mov(input logic [3:0] rd, input logic [7:0] v);
    return enc(1, 0, 0, 0, 1, 0, 3'd0, 3'd0, v, 4'd0, 4'd0, rd);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {4'b0, u_micro.r_z, u_micro.r_n, u_micro.r_c, u_micro.r_v};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic clear_pmem();
    for (int i = 0; i < 256; i++) u_micro.u_pmem.mem[i] = 32'h0;
  endtask

  // Hold reset for two cycles, then release on a falling edge.
  task automatic reset_hold();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic load_loop();
    clear_pmem();
    u_micro.u_pmem.mem[0] = 32'h00000001;
    u_micro.u_pmem.mem[1] = 32'h88000A01;
    u_micro.u_pmem.mem[2] = 32'h40000110;
    u_micro.u_pmem.mem[3] = 32'h84005002;
    u_micro.u_pmem.mem[4] = 32'h98801011;
    u_micro.u_pmem.mem[5] = 32'h21002000;
    u_micro.u_pmem.mem[6] = 32'h40000020;
    u_micro.u_pmem.mem[7] = 32'h4000B020;
    u_micro.u_pmem.mem[8] = 32'h2000F000;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    //            op    A      B      res    ZNCV
    vt[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101};
    vt[1]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 4'b0110};
    vt[2]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010};
    vt[3]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vt[4]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vt[5]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 4'b0100};
    vt[6]  = '{3'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000};
    vt[7]  = '{3'd5, 8'h5A, 8'h13, 8'hA5, 4'b0100};
    vt[8]  = '{3'd6, 8'h81, 8'h00, 8'h02, 4'b0010};
    vt[9]  = '{3'd7, 8'h81, 8'h00, 8'h40, 4'b0010};
    vt[10] = '{3'd7, 8'h02, 8'h00, 8'h01, 4'b0000};
    vt[11] = '{3'd1, 8'h05, 8'h05, 8'h00, 4'b1000};

    // All-zero program: NOPs, PC walks and wraps.
    clear_pmem();
    reset_hold();
    chk("rst_pc", u_micro.r_pc, 8'h00);
    chk("rst_flags", flags(), 8'h00);
    chk("rst_r15", u_micro.r_rf[15], 8'h00);
    cyc(1); chk("nop_pc1", u_micro.r_pc, 8'h01);
    cyc(1); chk("nop_pc2", u_micro.r_pc, 8'h02);
    cyc(253); chk("nop_pc255", u_micro.r_pc, 8'hFF);
    cyc(1); chk("nop_wrap", u_micro.r_pc, 8'h00);
    chk("nop_r1", u_micro.r_rf[1], 8'h00);
    chk("nop_dmem", u_micro.u_dmem.r_mem[255], 8'h00);
    chk("nop_flags", flags(), 8'h00);

    // ALU table: r1=A, r2=B, r0 = r1 op r2 with flag write.
    for (int i = 0; i < 12; i++) begin
      rst_ni = 1'b0;
      clear_pmem();
      u_micro.u_pmem.mem[0] = mov(4'd1, vt[i].a);
      u_micro.u_pmem.mem[1] = mov(4'd2, vt[i].b);
      u_micro.u_pmem.mem[2] = enc(1, 0, 0, 1, 0, 0, 3'd0, vt[i].op, 8'h00, 4'd2, 4'd1, 4'd0);
      exp_q.push_back('{vt[i].res, vt[i].zncv});
      reset_hold();
      cyc(3);
      e = exp_q.pop_front();
      chk($sformatf("alu%0d_res", i), u_micro.r_rf[0], e.res);
      chk($sformatf("alu%0d_flags", i), flags(), {4'b0, e.zncv});
    end

    // Move then store.
    rst_ni = 1'b0;
    clear_pmem();
    u_micro.u_pmem.mem[0] = mov(4'd1, 8'h0A);
    u_micro.u_pmem.mem[1] = enc(0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 4'd0, 4'd1, 4'd0);
    reset_hold();
    cyc(1);
    chk("mov_r1", u_micro.r_rf[1], 8'h0A);
    chk("mov_dmem0_before", u_micro.u_dmem.r_mem[0], 8'h00);
    cyc(1);
    chk("st_dmem0", u_micro.u_dmem.r_mem[0], 8'h0A);

    // Conditional jumps on held flags.
    rst_ni = 1'b0;
    clear_pmem();
    u_micro.u_pmem.mem[0] = enc(0, 0, 0, 1, 1, 0, 3'd0, 3'd1, 8'h00, 4'd0, 4'd0, 4'd0);
    u_micro.u_pmem.mem[1] = enc(0, 0, 1, 0, 0, 0, 3'd2, 3'd0, 8'h02, 4'd0, 4'd0, 4'd0);
    u_micro.u_pmem.mem[2] = enc(0, 0, 1, 0, 0, 0, 3'd7, 3'd0, 8'h30, 4'd0, 4'd0, 4'd0);
    u_micro.u_pmem.mem[3] = enc(0, 0, 1, 0, 0, 0, 3'd1, 3'd0, 8'h40, 4'd0, 4'd0, 4'd0);
    reset_hold();
    cyc(1); chk("jz_flags", flags(), 8'h08);
    cyc(1); chk("jnz_not_taken", u_micro.r_pc, 8'h02);
    cyc(1); chk("jnever", u_micro.r_pc, 8'h03);
    cyc(1); chk("jz_taken", u_micro.r_pc, 8'h40);
    chk("jz_flags_held", flags(), 8'h08);

    // All four write enables in one instruction, then a load.
    rst_ni = 1'b0;
    clear_pmem();
    u_micro.u_pmem.mem[0]     = mov(4'd1, 8'h05);
    u_micro.u_pmem.mem[1]     = enc(1, 1, 1, 1, 1, 0, 3'd0, 3'd0, 8'h20, 4'd0, 4'd1, 4'd1);
    u_micro.u_pmem.mem[8'h20] = enc(1, 0, 0, 0, 0, 1, 3'd0, 3'd0, 8'h20, 4'd0, 4'd0, 4'd3);
    reset_hold();
    cyc(2);
    chk("all_r1", u_micro.r_rf[1], 8'h25);
    chk("all_dmem", u_micro.u_dmem.r_mem[8'h20], 8'h05);
    chk("all_pc", u_micro.r_pc, 8'h20);
    chk("all_flags", flags(), 8'h00);
    cyc(1);
    chk("ld_r3", u_micro.r_rf[3], 8'h05);

    // Load loop: r1 counts 0..255 and wraps, then the tail stores and jumps to 15.
    rst_ni = 1'b0;
    load_loop();
    reset_hold();
    cyc(1026);
    chk("loop_exit_pc", u_micro.r_pc, 8'h06);
    chk("loop_exit_dmem0", u_micro.u_dmem.r_mem[0], 8'hFF);
    cyc(3);
    chk("loop_pc", u_micro.r_pc, 8'h0F);
    chk("loop_r1", u_micro.r_rf[1], 8'h00);
    chk("loop_r2", u_micro.r_rf[2], 8'h00);
    chk("loop_flags", flags(), 8'h0A);
    chk("loop_dmem0", u_micro.u_dmem.r_mem[0], 8'h00);
    chk("loop_dmem11", u_micro.u_dmem.r_mem[11], 8'h00);
    cyc(2);
    chk("loop_nop_pc", u_micro.r_pc, 8'h11);

    // Reset in the middle of the loop, then rerun from address 0.
    rst_ni = 1'b0;
    reset_hold();
    cyc(102);
    chk("mid_pc", u_micro.r_pc, 8'h02);
    chk("mid_r1", u_micro.r_rf[1], 8'd25);
    chk("mid_dmem0", u_micro.u_dmem.r_mem[0], 8'd24);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_pc", u_micro.r_pc, 8'h00);
    chk("mid_rst_r1", u_micro.r_rf[1], 8'h00);
    chk("mid_rst_dmem0", u_micro.u_dmem.r_mem[0], 8'h00);
    chk("mid_rst_flags", flags(), 8'h00);
    n_tests++;
    if (u_micro.u_pmem.mem[4] !== 32'h98801011) begin
      n_fail++;
      $display("FAIL mid_rst_pmem: got %h, want %h", u_micro.u_pmem.mem[4], 32'h98801011);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1);
    chk("rerun_pc1", u_micro.r_pc, 8'h01);
    cyc(1028);
    chk("rerun_pc", u_micro.r_pc, 8'h0F);
    chk("rerun_flags", flags(), 8'h0A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
